// File: rtl/reg_file_nx2r1w_if.sv
// reg_file_nx2r1w_if: bundles the register-file write, clear and read signals.
// Ports: clr/we/wsel/wdata (write side), rsel_a/rsel_b (read selects), ra/rb (read data).
// master = decode/datapath side driving selects and write data; slave = register file.
interface reg_file_nx2r1w_if #(
  parameter int WIDTH = 32,
  parameter int SELW  = 4
);
  logic             clr;
  logic             we;
  logic [SELW-1:0]  wsel;
  logic [WIDTH-1:0] wdata;
  logic [SELW-1:0]  rsel_a;
  logic [SELW-1:0]  rsel_b;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;

  modport master (
    output clr, we, wsel, wdata, rsel_a, rsel_b,
    input  ra, rb
  );

  modport slave (
    input  clr, we, wsel, wdata, rsel_a, rsel_b,
    output ra, rb
  );
endinterface

// File: rtl/reg_file_nx2r1w.sv
// reg_file_nx2r1w: NREGS x WIDTH register file, one synchronous write port, two combinational read ports.
// Latency: writes land on the rising edge (visible next cycle); reads are combinational, optional same-cycle bypass.
// Ports: clk, rst_n (async active-low clear), bus (slave modport: clr, we, wsel, wdata, rsel_a, rsel_b -> ra, rb).
module reg_file_nx2r1w #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int SELW    = 4,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_file_nx2r1w_if.slave  bus
);

  // One extra bit so NREGS == 2**SELW is representable in the range compare.
  localparam logic [SELW:0] NREGS_L = (SELW + 1)'(NREGS);

  logic [WIDTH-1:0] r_regs [NREGS];

  logic w_wsel_ok;
  logic w_wr_ok;

  // A write is effective only when it would actually change a register.
  // rst_n is folded in so that bypass is also suppressed while in reset.
  always_comb begin
    w_wsel_ok = ({1'b0, bus.wsel} < NREGS_L) &&
                !((ZERO_R0 != 0) && (bus.wsel == '0));
    w_wr_ok   = rst_n && bus.we && !bus.clr && w_wsel_ok;
  end

  // Storage: clear beats write; the same decode gates both storage and bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.wsel == SELW'(i)) r_regs[i] <= bus.wdata;
      end
    end
  end

  // Read muxes. Priority: out-of-range / hardwired R0, then bypass, then storage.
  // Reset needs no explicit term: storage is already zero and w_wr_ok is low.
  always_comb begin
    bus.ra = '0;
    bus.rb = '0;

    if (({1'b0, bus.rsel_a} >= NREGS_L) || ((ZERO_R0 != 0) && (bus.rsel_a == '0))) begin
      bus.ra = '0;
    end else if ((BYPASS != 0) && w_wr_ok && (bus.wsel == bus.rsel_a)) begin
      bus.ra = bus.wdata;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.rsel_a == SELW'(i)) bus.ra = r_regs[i];
      end
    end

    if (({1'b0, bus.rsel_b} >= NREGS_L) || ((ZERO_R0 != 0) && (bus.rsel_b == '0))) begin
      bus.rb = '0;
    end else if ((BYPASS != 0) && w_wr_ok && (bus.wsel == bus.rsel_b)) begin
      bus.rb = bus.wdata;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.rsel_b == SELW'(i)) bus.rb = r_regs[i];
      end
    end
  end

endmodule

// File: doc/reg_file_nx2r1w.md
Name: reg_file_nx2r1w

Overview:
Parametrised processor register file: NREGS registers of WIDTH bits, one synchronous write port and two independent read ports. Each read port is a select-driven mux over the register array, generalising the 16-to-1 32-bit mux. The block adds storage, optional write-to-read bypass, an optional hardwired-zero R0 and a synchronous clear. It sits in the datapath between instruction decode (register selects) and the ALU/shifter operand inputs.

Parameters:
WIDTH, 32, data width of each register and port.
NREGS, 16, number of registers; legal range 2..2**SELW.
SELW, 4, width of every register select; must satisfy 2**SELW >= NREGS.
ZERO_R0, 0, 1 = R0 reads as 0 and ignores writes.
BYPASS, 1, 1 = a same-cycle write to the selected register is forwarded to the read port.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear of all registers.
we  in  1  write enable.
wsel  in  SELW  write register select.
wdata  in  WIDTH  write data.
rsel_a  in  SELW  read port A select.
rsel_b  in  SELW  read port B select.
ra  out  WIDTH  read port A data.
rb  out  WIDTH  read port B data.

Behaviour:
- Reset: rst_n low forces every register to 0 immediately, independent of clk. Because reads are combinational, ra and rb show 0 within the same delta. Reset asserted mid-write discards that write. Release of rst_n takes effect on the next rising edge.
- Clear: clr=1 at a rising edge sets all registers to 0. clr has priority over we in the same cycle, so a simultaneous write is discarded.
- Write: we=1, clr=0 at a rising edge stores wdata into R[wsel]. Latency is 1 cycle: the stored value is visible on a read path from the following cycle.
- Ignored writes:
  - wsel >= NREGS: no register changes.
  - ZERO_R0=1 and wsel=0: no register changes.
- Reads: ra = R[rsel_a] and rb = R[rsel_b], combinational, with no clock latency. Each port is independent; both ports may select the same register.
- Out-of-range read: a select >= NREGS returns 0 on that port.
- Zero R0: with ZERO_R0=1, a select of 0 returns 0 on that port. Bypass never applies to R0 in this mode.
- Bypass: with BYPASS=1, if we=1, clr=0, rst_n=1, wsel equals a port's select, and the write is not ignored, that port outputs wdata in the same cycle. With BYPASS=0 the port shows the old value until after the edge.
- Read priority, highest first: reset, out-of-range/zero-R0, bypass, stored value.
- Width: no arithmetic; data passes unmodified at WIDTH bits.
- No X propagation: after reset every read path is defined for every select value.

Test Plan:
- Reset and basic read/write (NREGS=16, WIDTH=32):
  - Pulse rst_n low; sweep rsel_a 0..15 → ra=0 for every select.
  - Write R[i]=32'h00000000+i for i=0..15, one per cycle, then sweep rsel_a and rsel_b in opposite orders → ra=i and rb=15-i each cycle.
- Bypass:
  - BYPASS=1: R5 holds 32'h5. Set we=1, wsel=5, wdata=32'h00010000, rsel_a=5 → ra=32'h00010000 before the edge and after it.
  - BYPASS=0: same stimulus → ra=32'h5 before the edge and 32'h00010000 after it.
- Zero R0 and out-of-range:
  - ZERO_R0=1: write 32'hA0 to R0 → ra=0 with rsel_a=0, both in the write cycle and after.
  - NREGS=12: write 32'hFFFFFFFF with wsel=13 → R0..R11 unchanged; rsel_b=13 gives rb=0.
- Clear versus write: R7=32'h70. Assert clr=1 and we=1, wsel=7, wdata=32'h77 in one cycle → after the edge R7=0 and all other registers=0.
- Asynchronous reset mid-operation: R15=32'hF, we=1, wsel=15, wdata=32'hAA. Drop rst_n 3 ns before the edge → ra (rsel_a=15)=0 immediately. The edge while in reset does not store 32'hAA. After releasing rst_n, R15 stays 0 until the next write.
- Parametrisation: WIDTH=8, NREGS=4, SELW=2. Write 8'h81, 8'h42, 8'h24, 8'h18 to R0..R3 → reads return exactly those values with no truncation or sign effects.
